// File: rtl/ides8_word_align_pkg.sv
// Shared types and helpers for the IDES8 word-alignment controller.
package ides8_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h6A;

  function automatic int slip_cnt_width(input int max_slips);
    return $clog2(max_slips + 1);
  endfunction

endpackage

// File: rtl/ides8_word_align_if.sv
// Link-side bundle of the IDES8 word-alignment controller: request, data and status.
interface ides8_word_align_if
  import ides8_align_pkg::*;
#(
  parameter int MAX_SLIPS = 16
);

  localparam int SLIP_W = slip_cnt_width(MAX_SLIPS);

  logic              start_i;
  logic              train_i;
  logic [7:0]        q_i;
  logic              calib_o;
  logic              busy_o;
  logic              locked_o;
  logic              fail_o;
  logic [SLIP_W-1:0] slip_cnt_o;

  modport master (
    output start_i, train_i, q_i,
    input  calib_o, busy_o, locked_o, fail_o, slip_cnt_o
  );

  modport slave (
    input  start_i, train_i, q_i,
    output calib_o, busy_o, locked_o, fail_o, slip_cnt_o
  );

endinterface

// File: rtl/ides8_word_align.sv
// IDES8 lane word aligner: slips the word boundary with CALIB until PATTERN is stable.
// Build option IDES8_ALIGN_MONITOR_EN enables loss-of-lock monitoring while LOCKED.
module ides8_word_align
  import ides8_align_pkg::*;
#(
  parameter logic [7:0] PATTERN       = DEFAULT_PATTERN,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SETTLE_CYCLES = 3,
  parameter int         MAX_SLIPS     = 16,
  parameter int         LOSS_COUNT    = 4
) (
  input  logic              clk,
  input  logic              rst_i,
  ides8_word_align_if.slave bus
);

`ifdef IDES8_ALIGN_MONITOR_EN
  localparam bit MONITOR_EN = 1'b1;
`else
  localparam bit MONITOR_EN = 1'b0;
`endif

  localparam int SLIP_W   = slip_cnt_width(MAX_SLIPS);
  localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int LOSS_W   = $clog2(LOSS_COUNT + 1);

  state_t              r_state, w_state_nx;
  logic [7:0]          r_q;
  logic [MATCH_W-1:0]  r_match_cnt, w_match_cnt_nx;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_cnt_nx;
  logic [SLIP_W-1:0]   r_slip_cnt, w_slip_cnt_nx;
  logic [LOSS_W-1:0]   r_loss_cnt, w_loss_cnt_nx;
  logic                r_calib, r_busy, r_locked, r_fail;
  logic                w_match, w_slips_left, w_miss_trained, w_lost;

  assign w_match        = (r_q == PATTERN);
  assign w_slips_left   = (r_slip_cnt < SLIP_W'(MAX_SLIPS));
  assign w_miss_trained = MONITOR_EN && bus.train_i && !w_match;
  assign w_lost         = w_miss_trained && (r_loss_cnt == LOSS_W'(LOSS_COUNT - 1));

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    w_state_nx      = r_state;
    w_match_cnt_nx  = r_match_cnt;
    w_settle_cnt_nx = r_settle_cnt;
    w_slip_cnt_nx   = r_slip_cnt;
    w_loss_cnt_nx   = '0;
    unique case (r_state)
      ST_IDLE, ST_FAIL: begin
        if (bus.start_i) begin
          w_state_nx     = ST_CHECK;
          w_match_cnt_nx = '0;
          w_slip_cnt_nx  = '0;
        end
      end
      ST_CHECK: begin
        // A full match count is acted on in the cycle after it is reached.
        if (r_match_cnt == MATCH_W'(MATCH_COUNT)) begin
          w_state_nx = ST_LOCKED;
        end else if (w_match) begin
          w_match_cnt_nx = r_match_cnt + 1'b1;
        end else begin
          w_match_cnt_nx = '0;
          w_state_nx     = w_slips_left ? ST_SLIP : ST_FAIL;
        end
      end
      ST_SLIP: begin
        if (w_slips_left) w_slip_cnt_nx = r_slip_cnt + 1'b1;
        w_settle_cnt_nx = '0;
        w_state_nx      = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_match_cnt_nx = '0;
        if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_settle_cnt_nx = '0;
          w_state_nx      = ST_CHECK;
        end else begin
          w_settle_cnt_nx = r_settle_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.start_i) begin
          w_state_nx     = ST_CHECK;
          w_match_cnt_nx = '0;
          w_slip_cnt_nx  = '0;
        end else if (w_lost) begin
          w_state_nx     = ST_SLIP;
          w_match_cnt_nx = '0;
          w_slip_cnt_nx  = '0;
        end else if (w_miss_trained) begin
          w_loss_cnt_nx = r_loss_cnt + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_q          <= '0;
      r_match_cnt  <= '0;
      r_settle_cnt <= '0;
      r_slip_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_calib      <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_q          <= bus.q_i;
      r_match_cnt  <= w_match_cnt_nx;
      r_settle_cnt <= w_settle_cnt_nx;
      r_slip_cnt   <= w_slip_cnt_nx;
      r_loss_cnt   <= w_loss_cnt_nx;
      r_calib      <= (w_state_nx == ST_SLIP);
      r_busy       <= (w_state_nx inside {ST_CHECK, ST_SLIP, ST_SETTLE});
      r_locked     <= (w_state_nx == ST_LOCKED);
      r_fail       <= (w_state_nx == ST_FAIL);
    end
  end

  assign bus.calib_o    = r_calib;
  assign bus.busy_o     = r_busy;
  assign bus.locked_o   = r_locked;
  assign bus.fail_o     = r_fail;
  assign bus.slip_cnt_o = r_slip_cnt;

endmodule

// File: tb/tb_ides8_word_align.sv
// Directed bench for ides8_word_align; the IDES8 lane is modelled as a word rotated once per CALIB pulse.
module tb_ides8_word_align;

  localparam logic [7:0] PAT = 8'h6A;

  logic clk = 1'b0;
  logic rst_i;

  ides8_word_align_if #(.MAX_SLIPS(16)) bus ();

  ides8_word_align #(
    .PATTERN      (PAT),
    .MATCH_COUNT  (4),
    .SETTLE_CYCLES(3),
    .MAX_SLIPS    (16),
    .LOSS_COUNT   (4)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         cyc        = 0;
  int         pulse_cnt  = 0;
  int         last_pulse = -1000;
  int         min_gap    = 1000;
  logic [2:0] base       = 3'd0;
  logic       force_en   = 1'b0;
  logic [7:0] force_val  = 8'h00;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input logic [2:0] k);
    return (w << k) | (w >> (4'd8 - {1'b0, k}));
  endfunction

  // Each CALIB pulse moves the model's word boundary by one bit.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.calib_o === 1'b1) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_pulse <= cyc;
      if (cyc - last_pulse < min_gap) min_gap <= cyc - last_pulse;
    end
  end

  always_comb bus.q_i = force_en ? force_val : rotl8(PAT, 3'(base + pulse_cnt[2:0]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int p0;
    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    bus.train_i = 1'b0;
    ticks(3);
    check("rst_busy",   32'(bus.busy_o),     0);
    check("rst_locked", 32'(bus.locked_o),   0);
    check("rst_fail",   32'(bus.fail_o),     0);
    check("rst_calib",  32'(bus.calib_o),    0);
    check("rst_slips",  32'(bus.slip_cnt_o), 0);
    rst_i = 1'b0;
    ticks(2);
    check("idle_busy", 32'(bus.busy_o), 0);

    // Aligned start: lock in cycle 6, no CALIB.
    p0 = pulse_cnt;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("t1_busy_c1", 32'(bus.busy_o), 1);
    ticks(4);
    check("t1_locked_c5", 32'(bus.locked_o), 0);
    tick();
    check("t1_locked_c6", 32'(bus.locked_o), 1);
    check("t1_busy_c6",   32'(bus.busy_o),   0);
    check("t1_slips",     32'(bus.slip_cnt_o), 0);
    check("t1_pulses",    32'(pulse_cnt - p0), 0);

    // Three bits off, restarted from LOCKED; start pulses in CHECK and SETTLE are ignored.
    base = 3'(3'd5 - pulse_cnt[2:0]);
    p0 = pulse_cnt;
    bus.start_i = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      bus.start_i = (c == 1 || c == 3);
      if (c == 1) begin
        check("t2_restart_slips",  32'(bus.slip_cnt_o), 0);
        check("t2_restart_locked", 32'(bus.locked_o),   0);
        check("t2_restart_busy",   32'(bus.busy_o),     1);
      end
      if (c == 2)  check("t2_calib_c2",   32'(bus.calib_o),  1);
      if (c == 20) check("t2_locked_c20", 32'(bus.locked_o), 0);
    end
    check("t2_locked_c21", 32'(bus.locked_o), 1);
    check("t2_slips",      32'(bus.slip_cnt_o), 3);
    check("t2_pulses",     32'(pulse_cnt - p0), 3);
    check("t2_min_gap",    32'(min_gap), 5);

    // Pattern never seen: 16 CALIB pulses then FAIL in cycle 82.
    force_val = 8'h00;
    force_en  = 1'b1;
    p0 = pulse_cnt;
    bus.start_i = 1'b1;
    for (int c = 1; c <= 82; c++) begin
      tick();
      bus.start_i = 1'b0;
      if (c == 81) check("t3_fail_c81", 32'(bus.fail_o), 0);
    end
    check("t3_fail",   32'(bus.fail_o),   1);
    check("t3_locked", 32'(bus.locked_o), 0);
    check("t3_busy",   32'(bus.busy_o),   0);
    check("t3_slips",  32'(bus.slip_cnt_o), 16);
    check("t3_pulses", 32'(pulse_cnt - p0), 16);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("t3_retry_busy",  32'(bus.busy_o),     1);
    check("t3_retry_slips", 32'(bus.slip_cnt_o), 0);
    check("t3_retry_fail",  32'(bus.fail_o),     0);

    // Reset in the SETTLE cycle after a CALIB pulse.
    tick();
    check("t4_calib_c2", 32'(bus.calib_o), 1);
    tick();
    check("t4_busy_c3", 32'(bus.busy_o), 1);
    rst_i = 1'b1;
    #1;
    check("t4_rst_busy",   32'(bus.busy_o),     0);
    check("t4_rst_calib",  32'(bus.calib_o),    0);
    check("t4_rst_locked", 32'(bus.locked_o),   0);
    check("t4_rst_fail",   32'(bus.fail_o),     0);
    check("t4_rst_slips",  32'(bus.slip_cnt_o), 0);
    p0 = pulse_cnt;
    #2;
    rst_i = 1'b0;
    ticks(10);
    check("t4_idle_busy",   32'(bus.busy_o),   0);
    check("t4_idle_locked", 32'(bus.locked_o), 0);
    check("t4_idle_pulses", 32'(pulse_cnt - p0), 0);

    // Lock, then four trained mismatches.
    force_en = 1'b0;
    base = 3'(3'd0 - pulse_cnt[2:0]);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    ticks(5);
    check("t5_locked", 32'(bus.locked_o), 1);
    bus.train_i = 1'b1;
    tick();
    force_val = 8'h00;
    force_en  = 1'b1;
    p0 = pulse_cnt;
    ticks(4);
    force_en = 1'b0;
    check("t5_locked_c4", 32'(bus.locked_o), 1);
    tick();
`ifdef IDES8_ALIGN_MONITOR_EN
    check("t5_lost_locked", 32'(bus.locked_o), 0);
    check("t5_lost_calib",  32'(bus.calib_o),  1);
    for (int i = 0; i < 200 && bus.locked_o !== 1'b1; i++) tick();
    check("t5_relocked", 32'(bus.locked_o),   1);
    check("t5_slips",    32'(bus.slip_cnt_o), 8);
    check("t5_pulses",   32'(pulse_cnt - p0), 8);
`else
    check("t5_hold_locked", 32'(bus.locked_o), 1);
    check("t5_hold_calib",  32'(bus.calib_o),  0);
    ticks(20);
    check("t5_still_locked", 32'(bus.locked_o), 1);
    check("t5_pulses",       32'(pulse_cnt - p0), 0);
`endif
    check("t5_no_fail", 32'(bus.fail_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
